// File: rtl/octave_downsample.sv
// 2:1 x/y decimator between octave filter banks: keeps even-column/even-row samples
// of one Gaussian plane and emits the four signed Difference-of-Gaussian planes alongside.
module octave_downsample #(
  parameter int dataW    = 8,
  parameter int frameW   = 640,
  parameter int frameH   = 480,
  parameter int scaleSel = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   frameStart,
  input  logic [5*dataW-1:0]     dataIn,
  output logic                   outEn,
  output logic                   outFrameStart,
  output logic [dataW-1:0]       dataOut,
  output logic [4*(dataW+1)-1:0] dogOut
);

  localparam int COL_W = (frameW > 1) ? $clog2(frameW) : 1;
  localparam int ROW_W = (frameH > 1) ? $clog2(frameH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(frameW - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(frameH - 1);

  logic [COL_W-1:0] col, col_next, cur_col;
  logic [ROW_W-1:0] row, row_next, cur_row;
  // Set once a frame boundary has been seen (explicit frameStart or a full-frame wrap);
  // until then the post-reset origin is only assumed, so it is not flagged as a frame start.
  logic             synced, synced_next;
  logic             keep, at_origin;
  logic [4*(dataW+1)-1:0] dog;

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    cur_col     = frameStart ? '0 : col;
    cur_row     = frameStart ? '0 : row;
    col_next    = col;
    row_next    = row;
    synced_next = synced;
    at_origin   = (cur_col == '0) && (cur_row == '0);
    keep        = en && !cur_col[0] && !cur_row[0];

    if (en) begin
      if (frameStart) synced_next = 1'b1;
      if (cur_col == COL_LAST) begin
        col_next = '0;
        if (cur_row == ROW_LAST) begin
          row_next    = '0;
          synced_next = 1'b1;
        end else begin
          row_next = cur_row + 1'b1;
        end
      end else begin
        col_next = cur_col + 1'b1;
        row_next = cur_row;
      end
    end
  end

  // Zero-extended subtraction: field k = plane k+1 - plane k, no saturation.
  always_comb begin
    dog = '0;
    for (int k = 0; k < 4; k++) begin
      dog[k*(dataW+1) +: dataW+1] = {1'b0, dataIn[(k+1)*dataW +: dataW]}
                                  - {1'b0, dataIn[k*dataW +: dataW]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      row           <= '0;
      synced        <= 1'b0;
      outEn         <= 1'b0;
      outFrameStart <= 1'b0;
      dataOut       <= '0;
      dogOut        <= '0;
    end else begin
      col           <= col_next;
      row           <= row_next;
      synced        <= synced_next;
      outEn         <= keep;
      outFrameStart <= keep && at_origin && (frameStart || synced);
      if (keep) begin
        dataOut <= dataIn[scaleSel*dataW +: dataW];
        dogOut  <= dog;
      end
    end
  end

endmodule

// File: tb/tb_octave_downsample.sv
// Directed bench for octave_downsample at frameW=8, frameH=4, scaleSel=2; expected
// values are hand-derived kept positions and DoG constants.
module tb_octave_downsample;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        frameStart;
  logic [39:0] dataIn;
  logic        outEn;
  logic        outFrameStart;
  logic [7:0]  dataOut;
  logic [35:0] dogOut;

  int checks = 0;
  int errors = 0;
  int pulses;
  logic [7:0] exp_last;
  logic [7:0] out_vals[$];

  octave_downsample #(.dataW(8), .frameW(8), .frameH(4), .scaleSel(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frameStart(frameStart), .dataIn(dataIn),
    .outEn(outEn), .outFrameStart(outFrameStart), .dataOut(dataOut), .dogOut(dogOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] pix(input logic [7:0] v);
    return {5{v}};
  endfunction

  // Drive one cycle, then check the registered response 1 time unit after the edge.
  task automatic step(input string tag, input logic e, input logic fs, input logic [39:0] d,
                      input logic exp_en, input logic exp_fs);
    en = e; frameStart = fs; dataIn = d;
    @(posedge clk); #1;
    if (exp_en) exp_last = d[23:16];
    check({tag, " outEn"}, 64'(outEn), 64'(exp_en));
    check({tag, " outFrameStart"}, 64'(outFrameStart), 64'(exp_fs));
    check({tag, " dataOut"}, 64'(dataOut), 64'(exp_last));
    if (outEn) begin
      pulses++;
      out_vals.push_back(dataOut);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; frameStart = 1'b0; dataIn = '0; exp_last = '0;
    #12;
    check("reset outEn", 64'(outEn), 64'd0);
    check("reset outFrameStart", 64'(outFrameStart), 64'd0);
    check("reset dataOut", 64'(dataOut), 64'd0);
    check("reset dogOut", 64'(dogOut), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One 8x4 frame: kept inputs are rows 0 and 2, even columns.
    pulses = 0;
    for (int i = 0; i < 32; i++)
      step("frame", 1'b1, i == 0, pix(8'(i)), i inside {0, 2, 4, 6, 16, 18, 20, 22}, i == 0);
    check("frame pulses", 64'(pulses), 64'd8);
    check("frame dogOut flat", 64'(dogOut), 64'd0);

    // Same stream, en toggled; the cycle after en=0 never strobes.
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      step("toggle on", 1'b1, i == 0, pix(8'(i)), i inside {0, 2, 4, 6, 16, 18, 20, 22}, i == 0);
      step("toggle off", 1'b0, 1'b0, pix(8'hAA), 1'b0, 1'b0);
    end
    check("toggle pulses", 64'(pulses), 64'd8);

    // DoG extremes: planes 0..4 = 255, 0, 255, 0, 0.
    step("dog", 1'b1, 1'b1, {8'd0, 8'd0, 8'd255, 8'd0, 8'd255}, 1'b1, 1'b1);
    check("dog fields", 64'(dogOut), 64'h405FF01);
    check("dog field0", 64'(dogOut[8:0]), 64'h101);
    check("dog field1", 64'(dogOut[17:9]), 64'h0FF);

    // Mid-frame resync on index 11 (which would otherwise sit at col 3, row 1).
    pulses = 0;
    for (int i = 0; i < 28; i++)
      step("resync", 1'b1, (i == 0) || (i == 11), pix(8'(i)),
           i inside {0, 2, 4, 6, 11, 13, 15, 17, 27}, (i == 0) || (i == 11));
    check("resync pulses", 64'(pulses), 64'd9);

    // Async reset between two kept samples.
    step("prerst", 1'b1, 1'b1, pix(8'd40), 1'b1, 1'b1);
    step("prerst", 1'b1, 1'b0, pix(8'd41), 1'b0, 1'b0);
    rst_n = 1'b0; en = 1'b0;
    #2;
    check("async outEn", 64'(outEn), 64'd0);
    check("async outFrameStart", 64'(outFrameStart), 64'd0);
    check("async dataOut", 64'(dataOut), 64'd0);
    check("async dogOut", 64'(dogOut), 64'd0);
    exp_last = '0;
    #2 rst_n = 1'b1;
    step("postrst", 1'b1, 1'b0, pix(8'd50), 1'b1, 1'b0);
    step("postrst", 1'b1, 1'b0, pix(8'd51), 1'b0, 1'b0);
    step("postrst", 1'b1, 1'b0, pix(8'd52), 1'b1, 1'b0);

    // Free-run across two frames with a single frameStart.
    pulses = 0;
    out_vals.delete();
    for (int i = 0; i < 64; i++)
      step("freerun", 1'b1, i == 0, pix(8'(i)),
           i inside {0, 2, 4, 6, 16, 18, 20, 22, 32, 34, 36, 38, 48, 50, 52, 54},
           (i == 0) || (i == 32));
    check("freerun pulses", 64'(pulses), 64'd16);
    if (out_vals.size() >= 9) check("freerun output9", 64'(out_vals[8]), 64'd32);
    else check("freerun output9 present", 64'(out_vals.size()), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
